uart_fifo_core: RTL and testbench

- Single-clock, parametrised UART with integrated baud generator, TX and RX FIFOs, configurable frame format (data bits, parity, stop bits) and sticky error reporting.
- Replaces separate-clock TX/RX UART instances.
- Sits between the host-side register/stream logic (push/pop handshakes) and the board serial pins.

---
 rtl/uart_fifo_core.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_uart_fifo_core.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_core.sv
// Single-clock UART: shared baud tick, TX and RX FIFOs, configurable frame format
// (data/parity/stop bits) and sticky error flags cleared by err_clr.
module uart_fifo_core #(
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int CLK_DIV    = 27,
   parameter int OVERSAMPLE = 16,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_wr,
   output logic                 tx_full,
   output logic                 tx_idle,
   output logic                 tx_out,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] rx_data,
   input  logic                 rx_rd,
   output logic                 rx_empty,
   input  logic                 err_clr,
   output logic                 tx_over_run,
   output logic                 rx_over_run,
   output logic                 rx_frame_err,
   output logic                 rx_parity_err
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);
   localparam int BC_W  = $clog2(DATA_BITS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2 - 1);
   localparam logic [BC_W-1:0]  DATA_LAST = BC_W'(DATA_BITS - 1);
   localparam logic [BC_W-1:0]  STOP_LAST = BC_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
      return (PARITY == 2) ? ~^d : ^d;
   endfunction

   function automatic logic line_level(input state_t s, input logic [DATA_BITS-1:0] sh,
                                       input logic p);
      case (s)
         S_START:  return 1'b0;
         S_DATA:   return sh[0];
         S_PARITY: return p;
         default:  return 1'b1;
      endcase
   endfunction

   // ---------------- baud tick ----------------
   logic [DIV_W-1:0] div_cnt;
   logic             tick;

   assign tick = (div_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (!reset_n)  div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + 1'b1;
   end

   // ---------------- TX FIFO ----------------
   logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
   logic [AW:0]          tx_wp, tx_rp;
   logic                 tx_empty, tx_push, tx_pop;
   logic [DATA_BITS-1:0] tx_head;

   assign tx_empty = (tx_wp == tx_rp);
   assign tx_full  = (tx_wp[AW] != tx_rp[AW]) && (tx_wp[AW-1:0] == tx_rp[AW-1:0]);
   assign tx_push  = tx_wr && !tx_full;
   assign tx_head  = tx_mem[tx_rp[AW-1:0]];

   // NOTE: storage arrays carry no reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= tx_data;
   end

   // ---------------- TX FSM ----------------
   state_t               tx_state, tx_state_n;
   logic [OS_W-1:0]      tx_tick, tx_tick_n;
   logic [BC_W-1:0]      tx_bit, tx_bit_n;
   logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
   logic                 tx_par, tx_par_n;

   always_comb begin
      // NOTE: every next-state variable takes its hold value first, so no path leaves one unassigned (no latches).
      tx_state_n = tx_state;
      tx_tick_n  = tx_tick;
      tx_bit_n   = tx_bit;
      tx_shift_n = tx_shift;
      tx_par_n   = tx_par;
      tx_pop     = 1'b0;
      case (tx_state)
         S_IDLE: begin
            if (tick && !tx_empty) begin
               tx_pop     = 1'b1;
               tx_state_n = S_START;
               tx_tick_n  = '0;
            end
         end
         default: begin
            if (tick) begin
               if (tx_tick != OS_LAST) begin
                  tx_tick_n = tx_tick + 1'b1;
               end else begin
                  tx_tick_n = '0;
                  tx_bit_n  = '0;
                  case (tx_state)
                     S_START: tx_state_n = S_DATA;
                     S_DATA: begin
                        tx_shift_n = tx_shift >> 1;
                        if (tx_bit == DATA_LAST) tx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        else                     tx_bit_n   = tx_bit + 1'b1;
                     end
                     S_PARITY: tx_state_n = S_STOP;
                     S_STOP: begin
                        // Chain straight into the next start bit so frames leave back to back.
                        if (tx_bit != STOP_LAST) begin
                           tx_bit_n = tx_bit + 1'b1;
                        end else if (!tx_empty) begin
                           tx_pop     = 1'b1;
                           tx_state_n = S_START;
                        end else begin
                           tx_state_n = S_IDLE;
                        end
                     end
                     default: tx_state_n = S_IDLE;
                  endcase
               end
            end
         end
      endcase
      if (tx_pop) begin
         tx_shift_n = tx_head;
         tx_par_n   = parity_of(tx_head);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_state <= S_IDLE;
         tx_tick  <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
         tx_out   <= 1'b1;
         tx_wp    <= '0;
         tx_rp    <= '0;
      end else begin
         tx_state <= tx_state_n;
         tx_tick  <= tx_tick_n;
         tx_bit   <= tx_bit_n;
         tx_shift <= tx_shift_n;
         tx_par   <= tx_par_n;
         tx_out   <= line_level(tx_state_n, tx_shift_n, tx_par_n);
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   assign tx_idle = (tx_state == S_IDLE) && tx_empty;

   // ---------------- RX synchroniser and FSM ----------------
   logic [1:0]           rx_sync;
   logic                 rx_s;
   state_t               rx_state, rx_state_n;
   logic [OS_W-1:0]      rx_tick, rx_tick_n;
   logic [BC_W-1:0]      rx_bit, rx_bit_n;
   logic [DATA_BITS-1:0] rx_shift, rx_shift_n;
   logic                 rx_par, rx_par_n;
   logic                 rx_done;

   assign rx_s = rx_sync[1];

   always_comb begin
      rx_state_n = rx_state;
      rx_tick_n  = rx_tick;
      rx_bit_n   = rx_bit;
      rx_shift_n = rx_shift;
      rx_par_n   = rx_par;
      rx_done    = 1'b0;
      if (tick) begin
         case (rx_state)
            S_IDLE: begin
               if (!rx_s) begin
                  rx_state_n = S_START;
                  rx_tick_n  = '0;
               end
            end
            S_START: begin
               if (rx_tick != OS_MID) begin
                  rx_tick_n = rx_tick + 1'b1;
               end else begin
                  rx_tick_n  = '0;
                  rx_bit_n   = '0;
                  rx_state_n = rx_s ? S_IDLE : S_DATA;
               end
            end
            default: begin
               if (rx_tick != OS_LAST) begin
                  rx_tick_n = rx_tick + 1'b1;
               end else begin
                  rx_tick_n = '0;
                  case (rx_state)
                     S_DATA: begin
                        rx_shift_n = {rx_s, rx_shift[DATA_BITS-1:1]};
                        if (rx_bit == DATA_LAST) rx_state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                        else                     rx_bit_n   = rx_bit + 1'b1;
                     end
                     S_PARITY: begin
                        rx_par_n   = rx_s;
                        rx_state_n = S_STOP;
                     end
                     default: begin
                        rx_done    = 1'b1;
                        rx_state_n = S_IDLE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

   // ---------------- RX FIFO and completion ----------------
   logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
   logic [AW:0]          rx_wp, rx_rp;
   logic                 rx_full, rx_push, rx_pop, par_ok, rx_good;

   assign rx_empty = (rx_wp == rx_rp);
   assign rx_full  = (rx_wp[AW] != rx_rp[AW]) && (rx_wp[AW-1:0] == rx_rp[AW-1:0]);
   assign rx_data  = rx_empty ? '0 : rx_mem[rx_rp[AW-1:0]];
   assign par_ok   = (PARITY == 0) || (parity_of(rx_shift) == rx_par);
   assign rx_good  = rx_done && rx_s && par_ok;
   assign rx_pop   = rx_rd && !rx_empty;
   assign rx_push  = rx_good && (!rx_full || rx_rd);

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= rx_shift;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rx_sync  <= 2'b11;
         rx_state <= S_IDLE;
         rx_tick  <= '0;
         rx_bit   <= '0;
         rx_shift <= '0;
         rx_par   <= 1'b0;
         rx_wp    <= '0;
         rx_rp    <= '0;
      end else begin
         rx_sync  <= {rx_sync[0], rx_in};
         rx_state <= rx_state_n;
         rx_tick  <= rx_tick_n;
         rx_bit   <= rx_bit_n;
         rx_shift <= rx_shift_n;
         rx_par   <= rx_par_n;
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   // Sticky flags: a new error in the same cycle as err_clr wins.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tx_over_run   <= 1'b0;
         rx_over_run   <= 1'b0;
         rx_frame_err  <= 1'b0;
         rx_parity_err <= 1'b0;
      end else begin
         if (tx_wr && tx_full)                 tx_over_run   <= 1'b1;
         else if (err_clr)                     tx_over_run   <= 1'b0;
         if (rx_good && rx_full && !rx_rd)     rx_over_run   <= 1'b1;
         else if (err_clr)                     rx_over_run   <= 1'b0;
         if (rx_done && !rx_s)                 rx_frame_err  <= 1'b1;
         else if (err_clr)                     rx_frame_err  <= 1'b0;
         if (rx_done && rx_s && !par_ok)       rx_parity_err <= 1'b1;
         else if (err_clr)                     rx_parity_err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Bench for uart_fifo_core: three instances (8N1 loopback, 7O2 format, 8E1 depth-4 overflow)
// checked against frame bit lists and byte queues derived from the frame rules.
module tb_uart_fifo_core;

   localparam int BIT_CLK = 64;

   logic clk = 1'b0, reset_n = 1'b0, err_clr = 1'b0;
   always #5 clk = ~clk;

   // u0: 8N1, depth 16
   logic [7:0] tx_data0 = '0, rx_data0;
   logic tx_wr0 = 1'b0, rx_rd0 = 1'b0, loop0 = 1'b1, drv0 = 1'b1;
   logic tx_full0, tx_idle0, tx_out0, rx_in0, rx_empty0, txo0, rxo0, rfe0, rpe0;
   assign rx_in0 = loop0 ? tx_out0 : drv0;

   // u1: 7 data bits, odd parity, 2 stop bits, loopback
   logic [6:0] tx_data1 = '0, rx_data1;
   logic tx_wr1 = 1'b0, rx_rd1 = 1'b0;
   logic tx_full1, tx_idle1, tx_out1, rx_empty1, txo1, rxo1, rfe1, rpe1;

   // u2: 8 data bits, even parity, depth 4
   logic [7:0] tx_data2 = '0, rx_data2;
   logic tx_wr2 = 1'b0, rx_rd2 = 1'b0, loop2 = 1'b0, drv2 = 1'b1;
   logic tx_full2, tx_idle2, tx_out2, rx_in2, rx_empty2, txo2, rxo2, rfe2, rpe2;
   assign rx_in2 = loop2 ? tx_out2 : drv2;

   uart_fifo_core #(.CLK_DIV(4)) u0 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data0), .tx_wr(tx_wr0), .tx_full(tx_full0),
      .tx_idle(tx_idle0), .tx_out(tx_out0), .rx_in(rx_in0), .rx_data(rx_data0), .rx_rd(rx_rd0),
      .rx_empty(rx_empty0), .err_clr(err_clr), .tx_over_run(txo0), .rx_over_run(rxo0),
      .rx_frame_err(rfe0), .rx_parity_err(rpe0));

   uart_fifo_core #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .CLK_DIV(4)) u1 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data1), .tx_wr(tx_wr1), .tx_full(tx_full1),
      .tx_idle(tx_idle1), .tx_out(tx_out1), .rx_in(tx_out1), .rx_data(rx_data1), .rx_rd(rx_rd1),
      .rx_empty(rx_empty1), .err_clr(err_clr), .tx_over_run(txo1), .rx_over_run(rxo1),
      .rx_frame_err(rfe1), .rx_parity_err(rpe1));

   uart_fifo_core #(.PARITY(1), .CLK_DIV(4), .FIFO_DEPTH(4)) u2 (
      .clk(clk), .reset_n(reset_n), .tx_data(tx_data2), .tx_wr(tx_wr2), .tx_full(tx_full2),
      .tx_idle(tx_idle2), .tx_out(tx_out2), .rx_in(rx_in2), .rx_data(rx_data2), .rx_rd(rx_rd2),
      .rx_empty(rx_empty2), .err_clr(err_clr), .tx_over_run(txo2), .rx_over_run(rxo2),
      .rx_frame_err(rfe2), .rx_parity_err(rpe2));

   int   n_checks = 0, n_pass = 0, n_fail = 0;
   logic exp_bits[$];
   logic [7:0] model[$];
   logic [7:0] bytes[6];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected line levels of one frame: start, data LSB first, optional parity, stop bits.
   function automatic void add_frame(input logic [7:0] d, input int nb, input int pm, input int ns);
      logic p = 1'b0;
      exp_bits.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         exp_bits.push_back(d[i]);
         p ^= d[i];
      end
      if (pm == 1) exp_bits.push_back(p);
      if (pm == 2) exp_bits.push_back(~p);
      for (int i = 0; i < ns; i++) exp_bits.push_back(1'b1);
   endfunction

   function automatic logic tx_line(input int sel);
      case (sel)
         0:       return tx_out0;
         1:       return tx_out1;
         default: return tx_out2;
      endcase
   endfunction

   // All tasks enter and leave on a falling clock edge.
   task automatic push(input int sel, input logic [7:0] d);
      case (sel)
         0: begin tx_data0 = d; tx_wr0 = 1'b1; end
         1: begin tx_data1 = d[6:0]; tx_wr1 = 1'b1; end
         default: begin tx_data2 = d; tx_wr2 = 1'b1; end
      endcase
      @(negedge clk);
      tx_wr0 = 1'b0; tx_wr1 = 1'b0; tx_wr2 = 1'b0;
   endtask

   task automatic pop_check(input int sel, input logic [7:0] d, input string tag);
      if (sel == 0) begin
         check({tag, " nonempty"}, rx_empty0, 1'b0);
         check({tag, " data"}, rx_data0, d);
         rx_rd0 = 1'b1;
      end else begin
         check({tag, " nonempty"}, rx_empty2, 1'b0);
         check({tag, " data"}, rx_data2, d);
         rx_rd2 = 1'b1;
      end
      @(negedge clk);
      rx_rd0 = 1'b0; rx_rd2 = 1'b0;
   endtask

   // Waits for the start bit, then compares every clock of every bit against exp_bits.
   task automatic check_stream(input int sel, input string tag);
      int waited = 0;
      int bad;
      while (tx_line(sel) !== 1'b0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      check({tag, " start seen"}, (waited < 400), 1'b1);
      for (int b = 0; b < exp_bits.size(); b++) begin
         bad = 0;
         repeat (BIT_CLK) begin
            if (tx_line(sel) !== exp_bits[b]) bad++;
            @(negedge clk);
         end
         check($sformatf("%s bit%0d", tag, b), bad, 0);
      end
   endtask

   task automatic drive(input int sel, input logic v);
      if (sel == 0) drv0 = v;
      else          drv2 = v;
   endtask

   task automatic send_frame(input int sel, input logic [7:0] d, input int pm,
                             input logic flip_par, input logic stop_v);
      logic p = 1'b0;
      drive(sel, 1'b0);
      repeat (BIT_CLK) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         drive(sel, d[i]);
         p ^= d[i];
         repeat (BIT_CLK) @(negedge clk);
      end
      if (pm != 0) begin
         drive(sel, ((pm == 2) ? ~p : p) ^ flip_par);
         repeat (BIT_CLK) @(negedge clk);
      end
      drive(sel, stop_v);
      repeat (BIT_CLK) @(negedge clk);
      drive(sel, 1'b1);
   endtask

   initial begin
      int waited;
      int cycles;
      repeat (3) @(negedge clk);
      // Reset state, sampled while reset is still held.
      check("rst tx_out", tx_out0, 1'b1);
      check("rst tx_idle", tx_idle0, 1'b1);
      check("rst tx_full", tx_full0, 1'b0);
      check("rst rx_empty", rx_empty0, 1'b1);
      check("rst rx_data", rx_data0, 8'h00);
      check("rst flags", {txo0, rxo0, rfe0, rpe0}, 4'b0000);
      reset_n = 1'b1;
      @(negedge clk);

      // 8N1 loopback, four frames back to back.
      exp_bits.delete();
      add_frame(8'h55, 8, 0, 1); add_frame(8'hA3, 8, 0, 1);
      add_frame(8'h00, 8, 0, 1); add_frame(8'hFF, 8, 0, 1);
      fork
         check_stream(0, "lb");
         begin
            push(0, 8'h55); push(0, 8'hA3); push(0, 8'h00); push(0, 8'hFF);
         end
      join
      repeat (10) @(negedge clk);
      check("lb tx_idle", tx_idle0, 1'b1);
      check("lb flags", {txo0, rxo0, rfe0, rpe0}, 4'b0000);
      pop_check(0, 8'h55, "lb0"); pop_check(0, 8'hA3, "lb1");
      pop_check(0, 8'h00, "lb2"); pop_check(0, 8'hFF, "lb3");
      check("lb drained", rx_empty0, 1'b1);

      // 7O2 format on u1.
      exp_bits.delete();
      add_frame(8'h41, 7, 2, 2);
      fork
         check_stream(1, "fmt");
         push(1, 8'h41);
      join
      repeat (10) @(negedge clk);
      check("fmt rx_data", rx_data1, 7'h41);
      check("fmt rx flags", {rfe1, rpe1}, 2'b00);

      // Frame error on u0 (stop bit low), parity error on u2.
      loop0 = 1'b0;
      send_frame(0, 8'h3C, 0, 1'b0, 1'b0);
      repeat (BIT_CLK * 2) @(negedge clk);
      check("ferr flag", rfe0, 1'b1);
      check("ferr empty", rx_empty0, 1'b1);
      check("ferr no perr", rpe0, 1'b0);
      send_frame(2, 8'h01, 1, 1'b1, 1'b1);
      repeat (BIT_CLK) @(negedge clk);
      check("perr flag", rpe2, 1'b1);
      check("perr empty", rx_empty2, 1'b1);
      check("perr no ferr", rfe2, 1'b0);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      check("clr ferr", rfe0, 1'b0);
      check("clr perr", rpe2, 1'b0);

      // Short low glitch is a false start; a valid frame right after is received.
      drive(0, 1'b0);
      repeat (20) @(negedge clk);
      drive(0, 1'b1);
      repeat (BIT_CLK * 2) @(negedge clk);
      check("glitch empty", rx_empty0, 1'b1);
      check("glitch flags", {rxo0, rfe0, rpe0}, 3'b000);
      send_frame(0, 8'h96, 0, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      pop_check(0, 8'h96, "glitch rx");
      loop0 = 1'b1;

      // Overflow on u2: one frame in flight plus four queued; the sixth write is dropped.
      loop2 = 1'b1;
      for (int i = 0; i < 6; i++) bytes[i] = 8'($urandom);
      push(2, bytes[0]);
      repeat (20) @(negedge clk);
      for (int i = 1; i < 5; i++) push(2, bytes[i]);
      check("ovf tx_full", tx_full2, 1'b1);
      check("ovf no txo yet", txo2, 1'b0);
      push(2, bytes[5]);
      check("ovf txo", txo2, 1'b1);
      check("ovf still full", tx_full2, 1'b1);
      waited = 0;
      while (!tx_idle2 && waited < 5000) begin
         @(negedge clk);
         waited++;
      end
      check("ovf tx done", tx_idle2, 1'b1);
      repeat (20) @(negedge clk);
      check("ovf rxo", rxo2, 1'b1);
      check("ovf no frame/parity err", {rfe2, rpe2}, 2'b00);
      for (int i = 0; i < 4; i++) pop_check(2, bytes[i], $sformatf("ovf%0d", i));
      check("ovf drained", rx_empty2, 1'b1);

      // Reset in the middle of TX data bit 3.
      push(0, 8'hC3);
      waited = 0;
      while (tx_out0 !== 1'b0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      repeat (4 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mrst tx_out", tx_out0, 1'b1);
      check("mrst tx_idle", tx_idle0, 1'b1);
      check("mrst rx_empty", rx_empty0, 1'b1);
      check("mrst u0 flags", {txo0, rxo0, rfe0, rpe0}, 4'b0000);
      check("mrst u2 flags", {txo2, rxo2}, 2'b00);
      reset_n = 1'b1;
      @(negedge clk);
      exp_bits.delete();
      add_frame(8'h5A, 8, 0, 1);
      fork
         check_stream(0, "mrst frame");
         push(0, 8'h5A);
      join
      repeat (10) @(negedge clk);
      pop_check(0, 8'h5A, "mrst rx");
      check("mrst rx clean", rx_empty0, 1'b1);

      // Random bytes through the u0 loopback with random pop timing.
      for (int i = 0; i < 12; i++) begin
         logic [7:0] d;
         d = 8'($urandom);
         model.push_back(d);
         push(0, d);
      end
      cycles = 0;
      while (model.size() > 0 && cycles < 12 * 640 + 2000) begin
         if (!rx_empty0 && $urandom_range(0, 3) == 0) begin
            check($sformatf("rand %0d", 12 - model.size()), rx_data0, model.pop_front());
            rx_rd0 = 1'b1;
         end else begin
            rx_rd0 = 1'b0;
         end
         @(negedge clk);
         cycles++;
      end
      rx_rd0 = 1'b0;
      check("rand drained", model.size(), 0);
      repeat (BIT_CLK) @(negedge clk);
      check("rand tx_idle", tx_idle0, 1'b1);
      check("rand rx_empty", rx_empty0, 1'b1);
      check("rand flags", {txo0, rxo0, rfe0, rpe0}, 4'b0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
